// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared constants for the sequential shift-add multiplier:
//             default operand width and controller state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int c_DEFAULT_WIDTH = 16;

    // Controller states: IDLE waits for START, CALC runs one shift-add per
    // clock, FIX applies the sign and publishes the product.
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mult_ctrl
//  Purpose  : Controller for seq_multiplier. Owns the IDLE/CALC/FIX state
//             machine, the iteration counter, BUSY/DONE generation and the
//             early-exit decision.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             i_start             - operation request (honoured in IDLE only)
//             i_bm_init_zero      - multiplier magnitude being captured is 0
//             i_bm_next_zero      - multiplier register is 0 after this shift
//             o_load/o_calc/o_fix - datapath step enables
//             o_busy, o_done      - handshake outputs (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH      = c_DEFAULT_WIDTH,
    parameter int EARLY_EXIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_bm_init_zero,
    input  logic i_bm_next_zero,
    output logic o_load,
    output logic o_calc,
    output logic o_fix,
    output logic o_busy,
    output logic o_done
);

    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic               c_EARLY    = (EARLY_EXIT != 0);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    assign o_load = (r_state == c_ST_IDLE) && i_start;
    assign o_calc = (r_state == c_ST_CALC);
    assign o_fix  = (r_state == c_ST_FIX);
    assign o_busy = r_busy;
    assign o_done = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (i_start) begin
                        r_cnt  <= c_CNT_INIT;
                        r_busy <= 1'b1;
                        // A zero multiplier needs no iterations at all.
                        r_state <= (c_EARLY && i_bm_init_zero) ? c_ST_FIX : c_ST_CALC;
                    end
                end
                c_ST_CALC: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if ((r_cnt == c_CNT_ONE) || (c_EARLY && i_bm_next_zero)) begin
                        r_state <= c_ST_FIX;
                    end
                end
                c_ST_FIX: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : mult_ctrl
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_multiplier
//  Purpose  : Sequential shift-add multiplier, signed or unsigned, with
//             optional early termination and a START/BUSY/DONE handshake.
//             Signed operands are multiplied as magnitudes; the sign is
//             applied once in the FIX step.
//  Ports    : CLK, RST          - clock, synchronous active-high reset
//             START             - request, sampled while BUSY=0
//             SIGNED_MODE       - 1 = two's-complement operands
//             A_IN, B_IN        - multiplicand, multiplier (WIDTH bits)
//             BUSY, DONE        - handshake; DONE is a one-cycle pulse
//             PRODUCT, ZF       - 2*WIDTH-bit result and its zero flag
//  Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH      = c_DEFAULT_WIDTH,
    parameter int EARLY_EXIT = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               SIGNED_MODE,
    input  logic [WIDTH-1:0]   A_IN,
    input  logic [WIDTH-1:0]   B_IN,
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] PRODUCT,
    output logic               ZF
);

    localparam int c_PW = 2 * WIDTH;

    logic [c_PW-1:0]  r_am;
    logic [WIDTH-1:0] r_bm;
    logic [c_PW-1:0]  r_acc;
    logic             r_neg;
    logic [c_PW-1:0]  r_product;
    logic             r_zf;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [c_PW-1:0]  w_result;
    logic             w_load;
    logic             w_calc;
    logic             w_fix;
    logic             w_busy;
    logic             w_done;
    logic             w_bm_init_zero;
    logic             w_bm_next_zero;

    // Magnitudes fit in WIDTH unsigned bits, including |-2^(WIDTH-1)|.
    assign w_a_neg = SIGNED_MODE & A_IN[WIDTH-1];
    assign w_b_neg = SIGNED_MODE & B_IN[WIDTH-1];
    assign w_a_mag = w_a_neg ? (-A_IN) : A_IN;
    assign w_b_mag = w_b_neg ? (-B_IN) : B_IN;

    assign w_bm_init_zero = (w_b_mag == '0);
    assign w_bm_next_zero = (r_bm[WIDTH-1:1] == '0);

    // Negating zero yields zero, so ZF never disagrees with the sign fix.
    assign w_result = r_neg ? (-r_acc) : r_acc;

    mult_ctrl #(
        .WIDTH      (WIDTH),
        .EARLY_EXIT (EARLY_EXIT)
    ) u_ctrl (
        .clk            (CLK),
        .rst            (RST),
        .i_start        (START),
        .i_bm_init_zero (w_bm_init_zero),
        .i_bm_next_zero (w_bm_next_zero),
        .o_load         (w_load),
        .o_calc         (w_calc),
        .o_fix          (w_fix),
        .o_busy         (w_busy),
        .o_done         (w_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_am      <= '0;
            r_bm      <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
            r_zf      <= 1'b1;
        end else if (w_load) begin
            r_am  <= {{WIDTH{1'b0}}, w_a_mag};
            r_bm  <= w_b_mag;
            r_acc <= '0;
            r_neg <= SIGNED_MODE & (A_IN[WIDTH-1] ^ B_IN[WIDTH-1]);
        end else if (w_calc) begin
            if (r_bm[0]) begin
                r_acc <= r_acc + r_am;
            end
            r_am <= r_am << 1;
            r_bm <= r_bm >> 1;
        end else if (w_fix) begin
            r_product <= w_result;
            r_zf      <= (w_result == '0);
        end
    end

    assign BUSY    = w_busy;
    assign DONE    = w_done;
    assign PRODUCT = r_product;
    assign ZF      = r_zf;

endmodule : seq_multiplier
`default_nettype wire

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised sequential shift-add multiplier with an integrated controller FSM. It replaces the earlier arrangement of a datapath plus an external controller. Operands are captured on START, and the product is produced over at most WIDTH iterations. The block adds signed/unsigned mode, optional early termination, a START/BUSY/DONE handshake and a registered zero flag. It is a self-contained arithmetic unit on the CLK domain.

Parameters:
WIDTH, 16, operand width in bits (minimum 2); PRODUCT is 2*WIDTH bits.
EARLY_EXIT, 1, when 1 iteration stops as soon as the remaining multiplier bits are zero; when 0, exactly WIDTH iterations run.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  synchronous, active-high reset.
START  input  1  request; sampled only when BUSY=0.
SIGNED_MODE  input  1  1 = two's-complement operands; 0 = unsigned. Captured with START.
A_IN  input  WIDTH  multiplicand, captured on the accepted START edge.
B_IN  input  WIDTH  multiplier, captured on the accepted START edge.
BUSY  output  1  high from the edge after an accepted START until the product edge.
DONE  output  1  one-cycle pulse; PRODUCT and ZF are valid in this cycle.
PRODUCT  output  2*WIDTH  result; held until the next product edge.
ZF  output  1  1 when PRODUCT==0; registered with PRODUCT.

Behaviour:
- Reset: RST=1 at an edge forces state IDLE and clears all of the following: BUSY=0, DONE=0, PRODUCT=0, ZF=1, internal accumulator, counter and operand registers.
- RST has priority over everything, including mid-operation and an edge where START is also high. The operation in flight is discarded and no DONE is produced.
- FSM states: IDLE, CALC, FIX.
- IDLE, START=1 (accept edge t0):
  - Operand capture: in signed mode, store the magnitudes |A| and |B| as WIDTH-bit unsigned values (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits). In unsigned mode, store A and B directly.
  - Store NEG = SIGNED_MODE & (A_IN[MSB] ^ B_IN[MSB]).
  - Clear the 2*WIDTH-bit accumulator and set the counter to WIDTH.
  - Next state is CALC. If EARLY_EXIT=1 and the B magnitude is 0, next state is FIX instead.
- CALC, each edge:
  - If Bm[0]=1, ACC += Am_shifted (2*WIDTH-bit add; no overflow is possible).
  - Am_shifted <<= 1; Bm >>= 1; counter -= 1.
  - Go to FIX when counter reaches 0 after this edge, or when EARLY_EXIT=1 and the shifted Bm is 0.
- FIX, one edge:
  - PRODUCT <= NEG ? -ACC : ACC (two's complement in 2*WIDTH bits).
  - ZF <= (result==0). A zero result is never negated to a nonzero value.
  - DONE <= 1 for exactly one cycle, BUSY <= 0, next state IDLE.
- Latency: with k CALC iterations, DONE is high during the cycle after edge t0+k+1.
  - EARLY_EXIT=0: k = WIDTH.
  - EARLY_EXIT=1: k = index of the highest set bit of Bm plus 1, or 0 when Bm=0.
- BUSY is high after edges t0 through t0+k and low in the DONE cycle.
- START while BUSY=1 is ignored, with no effect on the operation in flight.
- START in the DONE cycle is accepted because the FSM is already in IDLE, giving back-to-back operation. PRODUCT stays valid until the next FIX edge.
- A_IN, B_IN and SIGNED_MODE may change freely after the accept edge.

Decomposition:
- Shared package mult_pkg: state enum (IDLE/CALC/FIX) and the WIDTH default constant.
- One natural sub-module, mult_ctrl: FSM, counter, BUSY/DONE generation, and the early-exit decision from a Bm-zero input.
- Datapath (operand registers, shift, add, sign fix, ZF) stays in seq_multiplier.

Test Plan:
1. WIDTH=16, EARLY_EXIT=0, unsigned, A=3, B=5, START at t0 -> BUSY high for 17 cycles; DONE pulse one cycle after edge t0+17; PRODUCT=0x0000000F; ZF=0.
2. Unsigned A=0xFFFF, B=0xFFFF -> PRODUCT=0xFFFE0001. Signed A=0xFFFD(-3), B=5 -> PRODUCT=0xFFFFFFF1. Signed A=B=0x8000 -> PRODUCT=0x40000000.
3. EARLY_EXIT=1, unsigned A=1234, B=0 -> DONE after edge t0+1, PRODUCT=0, ZF=1. Then A=7, B=5 (k=3) -> DONE after edge t0+4, PRODUCT=35.
4. START pulsed every cycle during the operation A=9, B=9 -> only the first START is accepted; a single DONE with PRODUCT=81. A START held during the DONE cycle launches the next operation immediately.
5. RST asserted at iteration 5 of A=100, B=200, with START also high on that edge -> next cycle BUSY=0, DONE=0, PRODUCT=0, ZF=1. No DONE follows; a new START gives the correct result 20000.
6. Randomised WIDTH=8 sweep of all signed and unsigned operand pairs -> PRODUCT matches a reference multiply; DONE count equals accepted START count.
